frame_uart_streamer: RTL and testbench
======================================

Name: frame_uart_streamer

Overview:
Parametrised successor to the canny-frame UART uplink. It captures one frame from the edge-detector pixel stream into an internal byte RAM, optionally packing 1-bit edges 8 per byte. It then transmits the frame over an integrated 8N1 UART as a framed packet: two sync bytes, then the payload, then an optional checksum. It sits between the canny pipeline and the board TX pin, feeding the pen-plotter host.

Parameters:
IMG_W, 176, pixels per line
IMG_H, 240, lines per frame
PIX_W, 8, input pixel width
PACK_EDGE, 1, 1: 8 px/byte, bit = (pix_data != 0), earliest pixel in LSB; 0: 1 byte/px, pix_data[PIX_W-1 -: 8]
CLK_HZ, 100000000, clock frequency
BAUD, 115200, UART baud rate
HDR0, 8'hAA, first sync byte
HDR1, 8'h55, second sync byte

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
pix_valid  in  1  pixel qualifier (canny_de)
pix_sof  in  1  start of frame; valid only with pix_valid, marks the first pixel
pix_data  in  PIX_W  pixel value (canny_data)
tx_en  in  1  1 = transmit captured frame; 0 = hold it in READY
tx  out  1  UART line, idle high
busy  out  1  high in every state except IDLE
frame_drop  out  1  one-cycle pulse when a frame/sof is discarded
frame_cnt  out  16  frames fully transmitted, wraps 65535 -> 0

Behaviour:
- Reset (reset == 0 at posedge): state IDLE; tx = 1, busy = 0, frame_drop = 0, frame_cnt = 0; RAM contents don't-care.
- NPIX = IMG_W*IMG_H. NBYTES = PACK_EDGE ? ceil(NPIX/8) : NPIX. Address width = $clog2(NBYTES).
- Bit period BITCLK = (CLK_HZ + BAUD/2) / BAUD clocks. Frame format: start 0, 8 data bits LSB first, stop 1 = 10*BITCLK clocks per byte. Bytes go back-to-back with no extra idle.
- FSM:
  - IDLE: pix_valid & pix_sof -> CAP. That pixel counts as pixel 0. Pixels without sof are ignored.
  - CAP: each pix_valid advances the pixel counter.
    - Packing: the bit shift register writes to RAM every 8th pixel.
    - Last pixel (count NPIX-1): write any partial byte with zero-padded upper bits, then -> READY.
    - pix_valid & pix_sof in CAP: restart capture at pixel 0 using this pixel, and pulse frame_drop.
  - READY: tx_en = 1 -> HDR0 on the next cycle. pix_valid & pix_sof in READY: ignore and pulse frame_drop. The held frame is kept.
  - HDR0, HDR1: send the sync bytes.
  - DATA: send RAM bytes 0..NBYTES-1 in order. The RAM has 1-cycle read latency; the next byte is prefetched during the current byte's stop bit, so bytes stay back-to-back.
  - CKSUM (only with the feature): send the checksum byte.
  - Transmit end: after the final stop bit completes, frame_cnt += 1 and go to IDLE in the same cycle.
- pix_valid & pix_sof in HDR0/HDR1/DATA/CKSUM: ignore and pulse frame_drop. No pixels are written to RAM outside CAP.
- tx_en is sampled only in READY. Dropping tx_en mid-transmit has no effect.
- A reset asserted mid-byte forces tx = 1 from the next cycle; the partial byte is abandoned.
- frame_drop asserts at most once per cycle, even if several drop conditions coincide.

Optional Feature:
FRAME_CKSUM_EN
- Defined: a checksum byte follows the payload. Value = XOR of all NBYTES payload bytes; sync bytes are excluded. The running XOR is cleared on entry to HDR0. Packet length = NBYTES + 3.
- Undefined: no CKSUM state and no checksum logic. Packet length = NBYTES + 2.

Test Plan:
1. Params IMG_W=4, IMG_H=4, PACK_EDGE=1, CLK_HZ=16, BAUD=1 (BITCLK=16). Stimulus: tx_en=1, sof + 16 pixels = 0,FF,0,FF,... -> line carries AA 55 AA AA. With FRAME_CKSUM_EN, byte 5 = 00. Each byte occupies exactly 160 clocks; frame_cnt 0 -> 1.
2. Same params, IMG_W=3, IMG_H=3. Stimulus: 9 pixels all FF -> payload FF 01; partial byte is zero-padded; total 4 bytes without the feature.
3. PACK_EDGE=0, IMG_W=2, IMG_H=2, pixels 12,34,56,78 -> AA 55 12 34 56 78. Checksum, if enabled, = 0x08.
4. tx_en=0 after capture: FSM holds READY with tx=1. A second sof -> frame_drop one cycle. Raise tx_en -> the original frame is sent unchanged.
5. sof after 5 pixels of a 16-pixel capture -> frame_drop pulse; capture restarts. Transmitted payload reflects only the second frame.
6. Reset low in the middle of DATA -> tx=1, busy=0, frame_cnt=0 on the next cycle. A fresh frame afterwards transmits correctly.

Source files
------------

// File: rtl/frame_uart_streamer.sv
// Captures one edge-detector frame into a byte RAM and uplinks it as an 8N1 UART packet
// (HDR0, HDR1, payload, optional XOR checksum enabled by the FRAME_CKSUM_EN macro).
module frame_uart_streamer #(
   parameter int         IMG_W     = 176,
   parameter int         IMG_H     = 240,
   parameter int         PIX_W     = 8,
   parameter int         PACK_EDGE = 1,
   parameter int         CLK_HZ    = 100000000,
   parameter int         BAUD      = 115200,
   parameter logic [7:0] HDR0      = 8'hAA,
   parameter logic [7:0] HDR1      = 8'h55
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_valid,
   input  logic             pix_sof,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             tx_en,
   output logic             tx,
   output logic             busy,
   output logic             frame_drop,
   output logic [15:0]      frame_cnt
);
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int NBYTES = (PACK_EDGE != 0) ? (NPIX + 7) / 8 : NPIX;
   localparam int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int PCW    = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int BITCLK = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int BCW    = (BITCLK > 1) ? $clog2(BITCLK) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CAP, S_READY, S_HDR0, S_HDR1, S_DATA
`ifdef FRAME_CKSUM_EN
      , S_CKSUM
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
   logic [7:0]       pack_q, pack_d;
   logic [9:0]       sh_q, sh_d;
   logic [BCW-1:0]   baud_q, baud_d;
   logic [3:0]       bit_q, bit_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             drop_q, drop_d;
`ifdef FRAME_CKSUM_EN
   logic [7:0]       cks_q, cks_d;
`endif

   logic [7:0]       ram_mem [NBYTES];
   logic [7:0]       rdata_q;
   logic             ram_we;
   logic [AW-1:0]    ram_waddr, ram_raddr;
   logic [7:0]       ram_wdata;

   logic             take_pix, last_pix, tx_active, bit_end, byte_done;
   logic [31:0]      cur_w;
   logic [7:0]       pack_base;

   assign tx_active = (state_q >= S_HDR0);
   assign bit_end   = (baud_q == BCW'(BITCLK - 1));
   assign byte_done = bit_end && (bit_q == 4'd9);

   // The read port runs one byte ahead of the byte on the line, so the next payload
   // byte is already in rdata_q when the current stop bit ends.
   assign ram_raddr = (state_q == S_DATA && idx_q != AW'(NBYTES - 1)) ? idx_q + AW'(1) : idx_q;

   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      pack_d      = pack_q;
      sh_d        = sh_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      drop_d      = 1'b0;
      ram_we      = 1'b0;
      ram_waddr   = '0;
      ram_wdata   = '0;
      take_pix    = 1'b0;
      cur_w       = 32'(pix_cnt_q);
      pack_base   = '0;
      last_pix    = 1'b0;
`ifdef FRAME_CKSUM_EN
      cks_d       = cks_q;
`endif

      if (tx_active) begin
         if (bit_end) begin
            baud_d = '0;
            bit_d  = bit_q + 4'd1;
            sh_d   = {1'b1, sh_q[9:1]};
         end else begin
            baud_d = baud_q + BCW'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (pix_valid && pix_sof) begin
               take_pix = 1'b1;
               cur_w    = '0;
            end
         end
         S_CAP: begin
            if (pix_valid) begin
               take_pix = 1'b1;
               if (pix_sof) begin
                  cur_w  = '0;
                  drop_d = 1'b1;
               end
            end
         end
         S_READY: begin
            if (pix_valid && pix_sof) drop_d = 1'b1;
            if (tx_en) begin
               state_d = S_HDR0;
               sh_d    = {1'b1, HDR0, 1'b0};
               baud_d  = '0;
               bit_d   = '0;
               idx_d   = '0;
`ifdef FRAME_CKSUM_EN
               cks_d   = '0;
`endif
            end
         end
         S_HDR0: begin
            if (byte_done) begin
               state_d = S_HDR1;
               sh_d    = {1'b1, HDR1, 1'b0};
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         S_HDR1: begin
            if (byte_done) begin
               state_d = S_DATA;
               sh_d    = {1'b1, rdata_q, 1'b0};
               baud_d  = '0;
               bit_d   = '0;
`ifdef FRAME_CKSUM_EN
               cks_d   = cks_q ^ rdata_q;
`endif
            end
         end
         S_DATA: begin
            if (byte_done) begin
               baud_d = '0;
               bit_d  = '0;
               if (idx_q == AW'(NBYTES - 1)) begin
`ifdef FRAME_CKSUM_EN
                  state_d = S_CKSUM;
                  sh_d    = {1'b1, cks_q, 1'b0};
`else
                  state_d     = S_IDLE;
                  sh_d        = '1;
                  frame_cnt_d = frame_cnt_q + 16'd1;
`endif
               end else begin
                  idx_d = idx_q + AW'(1);
                  sh_d  = {1'b1, rdata_q, 1'b0};
`ifdef FRAME_CKSUM_EN
                  cks_d = cks_q ^ rdata_q;
`endif
               end
            end
         end
`ifdef FRAME_CKSUM_EN
         S_CKSUM: begin
            if (byte_done) begin
               state_d     = S_IDLE;
               sh_d        = '1;
               baud_d      = '0;
               bit_d       = '0;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (tx_active && pix_valid && pix_sof) drop_d = 1'b1;

      // A byte is written when its 8th pixel arrives or when the frame ends early;
      // the base is cleared at each byte start, which zero-pads a trailing partial byte.
      if (take_pix) begin
         last_pix = (cur_w == 32'(NPIX - 1));
         if (PACK_EDGE != 0) begin
            pack_base = (cur_w[2:0] == 3'd0) ? 8'd0 : pack_q;
            pack_d    = pack_base | (8'(pix_data != '0) << cur_w[2:0]);
            ram_wdata = pack_d;
            ram_waddr = AW'(cur_w >> 3);
            ram_we    = (cur_w[2:0] == 3'd7) || last_pix;
         end else begin
            ram_wdata = pix_data[PIX_W-1 -: 8];
            ram_waddr = AW'(cur_w);
            ram_we    = 1'b1;
         end
         if (last_pix) begin
            state_d   = S_READY;
            pix_cnt_d = '0;
         end else begin
            state_d   = S_CAP;
            pix_cnt_d = PCW'(cur_w + 32'd1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pix_cnt_q   <= '0;
         sh_q        <= '1;
         baud_q      <= '0;
         bit_q       <= '0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         sh_q        <= sh_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         drop_q      <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      pack_q <= pack_d;
`ifdef FRAME_CKSUM_EN
      cks_q  <= cks_d;
`endif
      if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
      rdata_q <= ram_mem[ram_raddr];
   end

   assign tx         = sh_q[0];
   assign busy       = (state_q != S_IDLE);
   assign frame_drop = drop_q;
   assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_frame_uart_streamer.sv
// Bench for frame_uart_streamer: three instances (packed 4x4, packed 3x3, byte 2x2) checked
// against a queue-based packet model and a bit-timed UART receiver.
module tb_frame_uart_streamer;
   localparam int BC = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_valid = 1'b0;
   logic       pix_sof = 1'b0;
   logic [7:0] pix_data = 8'd0;
   logic       tx_en = 1'b0;
   logic [1:0] sel = 2'd0;

   logic        tx_v [3];
   logic        busy_v [3];
   logic        drop_v [3];
   logic [15:0] cnt_v [3];
   logic        tx_s, busy_s, drop_s;
   logic [15:0] cnt_s;

   int checks = 0;
   int errors = 0;
   int drop_cnt = 0;
   int exp_cnt [3] = '{0, 0, 0};

   logic [7:0] pix_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] rx_q [$];
   logic       rx_tmo, rx_fmt;

   always #5 clk = ~clk;

   assign tx_s   = tx_v[sel];
   assign busy_s = busy_v[sel];
   assign drop_s = drop_v[sel];
   assign cnt_s  = cnt_v[sel];

   always @(negedge clk) if (drop_s === 1'b1) drop_cnt++;

   frame_uart_streamer #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .PACK_EDGE(1), .CLK_HZ(16), .BAUD(1))
   u_a (.clk(clk), .reset(reset), .pix_valid(pix_valid && sel == 2'd0), .pix_sof(pix_sof),
        .pix_data(pix_data), .tx_en(tx_en && sel == 2'd0), .tx(tx_v[0]), .busy(busy_v[0]),
        .frame_drop(drop_v[0]), .frame_cnt(cnt_v[0]));

   frame_uart_streamer #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .PACK_EDGE(1), .CLK_HZ(16), .BAUD(1))
   u_b (.clk(clk), .reset(reset), .pix_valid(pix_valid && sel == 2'd1), .pix_sof(pix_sof),
        .pix_data(pix_data), .tx_en(tx_en && sel == 2'd1), .tx(tx_v[1]), .busy(busy_v[1]),
        .frame_drop(drop_v[1]), .frame_cnt(cnt_v[1]));

   frame_uart_streamer #(.IMG_W(2), .IMG_H(2), .PIX_W(8), .PACK_EDGE(0), .CLK_HZ(16), .BAUD(1))
   u_c (.clk(clk), .reset(reset), .pix_valid(pix_valid && sel == 2'd2), .pix_sof(pix_sof),
        .pix_data(pix_data), .tx_en(tx_en && sel == 2'd2), .tx(tx_v[2]), .busy(busy_v[2]),
        .frame_drop(drop_v[2]), .frame_cnt(cnt_v[2]));

   // Reference packet: sync bytes, payload derived from pix_q, optional XOR byte.
   function automatic void build_expect(input int pack);
      logic [7:0] pl [$];
      logic [7:0] x;
      int nb;
      nb = pack ? (pix_q.size() + 7) / 8 : pix_q.size();
      for (int i = 0; i < nb; i++) pl.push_back(8'h00);
      for (int i = 0; i < pix_q.size(); i++) begin
         if (pack) begin
            if (pix_q[i] != 8'h00) pl[i / 8] = pl[i / 8] | (8'h01 << (i % 8));
         end else begin
            pl[i] = pix_q[i];
         end
      end
      exp_q.delete();
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      x = 8'h00;
      foreach (pl[i]) begin
         exp_q.push_back(pl[i]);
         x = x ^ pl[i];
      end
`ifdef FRAME_CKSUM_EN
      exp_q.push_back(x);
`endif
   endfunction

   function automatic void rand_pixels(input int n);
      pix_q.delete();
      for (int i = 0; i < n; i++)
         pix_q.push_back($urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00);
   endfunction

   task automatic send_frame(input int gaps);
      for (int i = 0; i < pix_q.size(); i++) begin
         if (gaps != 0 && $urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            @(negedge clk);
         end
         pix_valid = 1'b1;
         pix_sof   = (i == 0);
         pix_data  = pix_q[i];
         @(negedge clk);
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   // Samples mid-bit; also requires each start edge exactly 10 bit times after the last
   // and the line idle / busy low exactly when the final stop bit ends.
   task automatic rx_packet(input int nb);
      int t;
      logic [7:0] b;
      logic s0, sp;
      t = 0;
      rx_q.delete();
      rx_tmo = 1'b0;
      rx_fmt = 1'b1;
      while (tx_s !== 1'b0 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (tx_s !== 1'b0) begin
         rx_tmo = 1'b1;
         return;
      end
      for (int j = 0; j < nb; j++) begin
         if (tx_s !== 1'b0) rx_fmt = 1'b0;
         repeat (BC / 2) @(negedge clk);
         s0 = tx_s;
         for (int i = 0; i < 8; i++) begin
            repeat (BC) @(negedge clk);
            b[i] = tx_s;
         end
         repeat (BC) @(negedge clk);
         sp = tx_s;
         if (s0 !== 1'b0 || sp !== 1'b1) rx_fmt = 1'b0;
         rx_q.push_back(b);
         repeat (BC / 2 - 1) @(negedge clk);
         if (j == nb - 1 && busy_s !== 1'b1) rx_fmt = 1'b0;
         @(negedge clk);
      end
      if (tx_s !== 1'b1 || busy_s !== 1'b0) rx_fmt = 1'b0;
   endtask

   task automatic test_reset();
      sel = 2'd0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_s); end
      checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_s); end
      checks++; if (drop_s !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop_s); end
      checks++; if (cnt_s !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_s); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_pattern();
      sel = 2'd0;
      tx_en = 1'b1;
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back((i % 2) ? 8'hFF : 8'h00);
      build_expect(1);
      send_frame(0);
      rx_packet(exp_q.size());
      exp_cnt[0]++;
      checks++;
      if (rx_tmo || rx_fmt !== 1'b1 || rx_q.size() != exp_q.size()) begin
         errors++; $display("FAIL pattern_frame: tmo=%0d fmt=%0d len=%0d expected tmo=0 fmt=1 len=%0d", rx_tmo, rx_fmt, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL pattern_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (cnt_s !== 16'(exp_cnt[0])) begin errors++; $display("FAIL pattern_cnt: got %0d expected %0d", cnt_s, exp_cnt[0]); end
   endtask

   task automatic test_random_pack();
      for (int f = 0; f < 2; f++) begin
         for (int d = 0; d < 2; d++) begin
            sel = 2'(d);
            tx_en = 1'b1;
            if (d == 1 && f == 0) begin
               pix_q.delete();
               for (int i = 0; i < 9; i++) pix_q.push_back(8'hFF);
            end else begin
               rand_pixels(d == 0 ? 16 : 9);
            end
            build_expect(1);
            send_frame(1);
            rx_packet(exp_q.size());
            exp_cnt[d]++;
            checks++;
            if (rx_tmo || rx_fmt !== 1'b1 || rx_q.size() != exp_q.size()) begin
               errors++; $display("FAIL pack_frame d%0d: tmo=%0d fmt=%0d len=%0d expected tmo=0 fmt=1 len=%0d", d, rx_tmo, rx_fmt, rx_q.size(), exp_q.size());
            end
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
               checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL pack_byte d%0d.%0d: got %02h expected %02h", d, i, rx_q[i], exp_q[i]); end
            end
            checks++; if (cnt_s !== 16'(exp_cnt[d])) begin errors++; $display("FAIL pack_cnt d%0d: got %0d expected %0d", d, cnt_s, exp_cnt[d]); end
         end
      end
   endtask

   task automatic test_bytes();
      int d0;
      sel = 2'd2;
      tx_en = 1'b1;
      for (int f = 0; f < 2; f++) begin
         pix_q.delete();
         if (f == 0) pix_q = '{8'h12, 8'h34, 8'h56, 8'h78};
         else for (int i = 0; i < 4; i++) pix_q.push_back(8'($urandom_range(0, 255)));
         build_expect(0);
         send_frame(1);
         d0 = drop_cnt;
         fork
            rx_packet(exp_q.size());
            begin
               repeat (400) @(negedge clk);
               pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'hEE;
               @(negedge clk);
               pix_valid = 1'b0; pix_sof = 1'b0;
            end
         join
         exp_cnt[2]++;
         checks++;
         if (rx_tmo || rx_fmt !== 1'b1 || rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bytes_frame: tmo=%0d fmt=%0d len=%0d expected tmo=0 fmt=1 len=%0d", rx_tmo, rx_fmt, rx_q.size(), exp_q.size());
         end
         for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bytes_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
         end
         checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL bytes_tx_drop: got %0d pulses expected 1", drop_cnt - d0); end
         checks++; if (cnt_s !== 16'(exp_cnt[2])) begin errors++; $display("FAIL bytes_cnt: got %0d expected %0d", cnt_s, exp_cnt[2]); end
      end
   endtask

   task automatic test_hold();
      int d0;
      logic hold_ok;
      sel = 2'd0;
      tx_en = 1'b0;
      rand_pixels(16);
      build_expect(1);
      send_frame(1);
      hold_ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (tx_s !== 1'b1 || busy_s !== 1'b1) hold_ok = 1'b0;
      end
      checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL hold_ready: got %b expected 1 (tx=1 busy=1 throughout)", hold_ok); end
      d0 = drop_cnt;
      for (int i = 0; i < 6; i++) begin
         pix_valid = 1'b1; pix_sof = (i == 0); pix_data = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      pix_valid = 1'b0; pix_sof = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL hold_drop: got %0d pulses expected 1", drop_cnt - d0); end
      tx_en = 1'b1;
      rx_packet(exp_q.size());
      exp_cnt[0]++;
      checks++;
      if (rx_tmo || rx_fmt !== 1'b1 || rx_q.size() != exp_q.size()) begin
         errors++; $display("FAIL hold_frame: tmo=%0d fmt=%0d len=%0d expected tmo=0 fmt=1 len=%0d", rx_tmo, rx_fmt, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL hold_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_restart();
      int d0;
      sel = 2'd0;
      tx_en = 1'b1;
      d0 = drop_cnt;
      rand_pixels(5);
      send_frame(0);
      rand_pixels(16);
      build_expect(1);
      send_frame(1);
      rx_packet(exp_q.size());
      exp_cnt[0]++;
      checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL restart_drop: got %0d pulses expected 1", drop_cnt - d0); end
      checks++;
      if (rx_tmo || rx_fmt !== 1'b1 || rx_q.size() != exp_q.size()) begin
         errors++; $display("FAIL restart_frame: tmo=%0d fmt=%0d len=%0d expected tmo=0 fmt=1 len=%0d", rx_tmo, rx_fmt, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL restart_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (cnt_s !== 16'(exp_cnt[0])) begin errors++; $display("FAIL restart_cnt: got %0d expected %0d", cnt_s, exp_cnt[0]); end
   endtask

   task automatic test_mid_reset();
      int t;
      sel = 2'd2;
      tx_en = 1'b1;
      rand_pixels(4);
      build_expect(0);
      send_frame(0);
      t = 0;
      while (tx_s !== 1'b0 && t < 100) begin @(negedge clk); t++; end
      repeat (2 * 10 * BC + 40) @(negedge clk);
      checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy_s); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx_s); end
      checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_s); end
      checks++; if (cnt_s !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", cnt_s); end
      reset = 1'b1;
      exp_cnt = '{0, 0, 0};
      repeat (2) @(negedge clk);
      rand_pixels(4);
      build_expect(0);
      send_frame(1);
      rx_packet(exp_q.size());
      exp_cnt[2]++;
      checks++;
      if (rx_tmo || rx_fmt !== 1'b1 || rx_q.size() != exp_q.size()) begin
         errors++; $display("FAIL midrst_frame: tmo=%0d fmt=%0d len=%0d expected tmo=0 fmt=1 len=%0d", rx_tmo, rx_fmt, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (cnt_s !== 16'(exp_cnt[2])) begin errors++; $display("FAIL midrst_cnt_after: got %0d expected %0d", cnt_s, exp_cnt[2]); end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_random_pack();
      test_bytes();
      test_hold();
      test_restart();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
